instruction_cache: RTL and testbench
====================================

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed: 8 lines, 16-byte (4-word) blocks, direct-mapped, 10-bit effective byte address.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 PC  input  32  CPU fetch byte address; bits [31:10] and [1:0] ignored.
REQ-005 INSTRUCTION  output  32  fetched word; byte at address A in [7:0], A+3 in [31:24].
REQ-006 BUSYWAIT  output  1  high = INSTRUCTION not valid, CPU holds PC.
REQ-007 mem_read  output  1  block read request to instruction memory.
REQ-008 mem_address  output  6  block address {tag, index} to memory.
REQ-009 mem_readdata  input  128  returned block; word k at [32k+31:32k].
REQ-010 mem_busywait  input  1  memory busy; high while read in progress.

Function
REQ-011 Address split SHALL be: offset = PC[3:2], index = PC[6:4], tag = PC[9:7].
REQ-012 Each line SHALL hold valid (1 b), tag (3 b), data (128 b).
REQ-013 hit = valid[index] AND tag[index] == PC tag, evaluated combinationally.
REQ-014 FSM states SHALL be IDLE, MEM_READ, UPDATE.
REQ-015 IDLE: BUSYWAIT = NOT hit; INSTRUCTION = data[index] word[offset] combinationally; mem_read = 0.
REQ-016 IDLE, miss at rising edge: latch miss tag/index, go to MEM_READ.
REQ-017 MEM_READ: mem_read = 1, mem_address = latched {tag, index}, BUSYWAIT = 1; stay while mem_busywait = 1.
REQ-018 MEM_READ, mem_busywait = 0 at rising edge: go to UPDATE.
REQ-019 UPDATE: at rising edge write mem_readdata into latched line, set valid = 1, tag = latched tag, return to IDLE; BUSYWAIT = 1, mem_read = 0 during UPDATE.
REQ-020 After return to IDLE, hit SHALL be re-evaluated against current PC; matching PC yields BUSYWAIT = 0 in that same cycle.
REQ-021 Hit latency SHALL be 0 cycles (same-cycle); miss costs memory latency + 2 cycles (MEM_READ entry, UPDATE).
REQ-022 PC changes while not in IDLE SHALL NOT alter mem_address or the line filled.
REQ-023 Miss to a valid line with different tag SHALL overwrite it (no write-back; read-only cache).
REQ-024 mem_readdata SHALL be sampled only at the UPDATE edge.
REQ-025 INSTRUCTION outside IDLE-hit is don't-care but SHALL hold no X from uninitialised valid lines after reset (drive data of the indexed line).

Reset
REQ-026 RESET high at rising edge SHALL clear all valid bits, force IDLE, clear latched tag/index to 0.
REQ-027 After reset edge: mem_read = 0, mem_address = 0, BUSYWAIT = NOT hit (= 1 for any PC).
REQ-028 While RESET is high, BUSYWAIT SHALL be 0 and mem_read SHALL be 0.
REQ-029 RESET during MEM_READ or UPDATE SHALL abort the fetch: no line written, mem_read low from the next cycle, late mem_busywait deassertion ignored.

Verification
REQ-030 Cold miss: reset, PC = 0x000, memory 3-cycle latency returns block 0x00000003_00000002_00000001_00000000 -> mem_read high with mem_address = 0 until done, then INSTRUCTION = 0x00000000, BUSYWAIT = 0.
REQ-031 Hits in block: after REQ-030 fill, PC = 0x004, 0x008, 0x00C -> INSTRUCTION = 1, 2, 3 same cycle, BUSYWAIT = 0, mem_read never asserted.
REQ-032 Conflict: PC = 0x080 (tag 1, index 0) after REQ-030 -> miss, mem_address = 0x08; after fill, PC = 0x000 misses again.
REQ-033 PC change mid-miss: miss on PC = 0x010, change PC to 0x020 during MEM_READ -> mem_address stays 0x01, line 1 filled, then miss on 0x020 starts.
REQ-034 Reset mid-fetch: assert RESET for one edge during MEM_READ -> mem_read = 0 next cycle, all lines invalid, PC = 0x000 misses again.
REQ-035 Upper-bit alias: PC = 0x400 after REQ-030 fill -> hit, INSTRUCTION = 0x00000000.

Source files
------------

// File: rtl/instruction_cache.sv
// ---------------------------------------------------------------------------
// instruction_cache
//   Read-only, direct-mapped instruction cache: 8 lines of 16-byte (4-word)
//   blocks over a 10-bit byte address. Hits return the word in the same
//   cycle. A miss fetches the whole block from instruction memory and then
//   refills the line.
//
// Ports
//   CLK           in   1    single clock, rising edge
//   RESET         in   1    synchronous, active-high reset
//   PC            in   32   fetch byte address (bits [31:10] and [1:0] unused)
//   INSTRUCTION   out  32   fetched word (byte at PC in [7:0])
//   BUSYWAIT      out  1    high while INSTRUCTION is not yet valid
//   mem_read      out  1    block read request to instruction memory
//   mem_address   out  6    block address {tag, index} of the pending miss
//   mem_readdata  in   128  returned block, word k at [32k+31:32k]
//   mem_busywait  in   1    memory busy while the read is in progress
//
// Memory handshake: mem_read is held high with a stable mem_address for the
// whole MEM_READ state; the block is taken from mem_readdata on the edge
// that leaves UPDATE, i.e. one cycle after mem_busywait was seen low.
// ---------------------------------------------------------------------------
module instruction_cache (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   valid_q, valid_d;
    logic [2:0]   tag_q  [8];
    logic [2:0]   tag_d  [8];
    logic [127:0] data_q [8];
    logic [127:0] data_d [8];
    logic [2:0]   miss_tag_q, miss_tag_d;
    logic [2:0]   miss_index_q, miss_index_d;
    logic         mem_read_q, mem_read_d;

    logic [1:0]   pc_offset;
    logic [2:0]   pc_index;
    logic [2:0]   pc_tag;
    logic         hit;
    logic [127:0] line_data;
    logic         unused_pc;

    assign pc_offset = PC[3:2];
    assign pc_index  = PC[6:4];
    assign pc_tag    = PC[9:7];
    assign unused_pc = ^{PC[31:10], PC[1:0]};

    assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign line_data = data_q[pc_index];

    // The indexed line is always driven, so the word is don't-care outside
    // an IDLE hit but never X (data is cleared on reset).
    assign INSTRUCTION = line_data[{pc_offset, 5'b00000} +: 32];

    // Reset masks the CPU-facing stall and the memory request immediately.
    assign BUSYWAIT    = RESET ? 1'b0 : ((state_q == IDLE) ? !hit : 1'b1);
    assign mem_read    = mem_read_q && !RESET;
    assign mem_address = {miss_tag_q, miss_index_q};

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        mem_read_d   = mem_read_q;

        case (state_q)
            IDLE: begin
                // Latch the missing block so later PC changes cannot
                // redirect the fetch or the refill.
                if (!hit) begin
                    miss_tag_d   = pc_tag;
                    miss_index_d = pc_index;
                    mem_read_d   = 1'b1;
                    state_d      = MEM_READ;
                end
            end
            MEM_READ: begin
                if (!mem_busywait) begin
                    mem_read_d = 1'b0;
                    state_d    = UPDATE;
                end
            end
            UPDATE: begin
                valid_d[miss_index_q] = 1'b1;
                tag_d[miss_index_q]   = miss_tag_q;
                data_d[miss_index_q]  = mem_readdata;
                state_d               = IDLE;
            end
            default: begin
                mem_read_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            mem_read_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
            mem_read_q   <= mem_read_d;
            for (int i = 0; i < 8; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// ---------------------------------------------------------------------------
// tb_instruction_cache
//   Drives instruction_cache with directed scenarios followed by random
//   fetches, against a block-level model of the cache (which memory block
//   each line holds) and a memory responder with a per-miss latency.
//   Memory latency L = number of cycles mem_read is high; a miss therefore
//   stalls for L + 2 rising edges before the word is available.
// ---------------------------------------------------------------------------
module tb_instruction_cache;

    logic         clk;
    logic         reset;
    logic [31:0]  pc;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    instruction_cache dut (
        .CLK          (clk),
        .RESET        (reset),
        .PC           (pc),
        .INSTRUCTION  (instruction),
        .BUSYWAIT     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory responder ----------------
    logic [31:0] mem_words [64][4];
    int          lat;
    int          mem_cnt;

    always @(posedge clk) mem_cnt <= mem_read ? mem_cnt + 1 : 0;

    assign mem_busywait = mem_read && (mem_cnt < lat - 1);
    assign mem_readdata = {mem_words[mem_address][3], mem_words[mem_address][2],
                           mem_words[mem_address][1], mem_words[mem_address][0]};

    // ---------------- reference model ----------------
    // Each line records which 6-bit block number it holds, -1 when empty.
    int m_blk [8];
    int errors;
    int checks;

    function automatic bit model_hit(input logic [31:0] a);
        return m_blk[a[6:4]] == int'(a[9:4]);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return mem_words[a[9:4]][a[3:2]];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_blk[i] = -1;
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge with the cache idle. Presents pc0,
    // follows any miss to completion (optionally switching PC to alt right
    // after the miss is accepted) and ends once the current PC hits.
    task automatic access(input logic [31:0] pc0, input bit sw, input logic [31:0] alt,
                          input int force_lat);
        logic [31:0] cur;
        logic [31:0] miss_pc;
        int          n;
        cur = pc0;
        pc  = pc0;
        for (int r = 0; r < 3; r++) begin
            #2;
            if (model_hit(cur)) begin
                check_eq("hit_busywait", 32'(busywait), 32'd0);
                check_eq("hit_instruction", instruction, model_word(cur));
                check_eq("hit_mem_read", 32'(mem_read), 32'd0);
                break;
            end
            check_eq("miss_busywait", 32'(busywait), 32'd1);
            check_eq("miss_idle_mem_read", 32'(mem_read), 32'd0);
            lat     = (force_lat > 0) ? force_lat : int'($urandom_range(1, 5));
            miss_pc = cur;
            n       = lat + 2;
            for (int e = 1; e <= n; e++) begin
                @(negedge clk);
                if (sw && r == 0 && e == 1) begin
                    cur = alt;
                    pc  = alt;
                end
                #2;
                check_eq("fill_mem_read", 32'(mem_read), (e <= lat) ? 32'd1 : 32'd0);
                if (e <= lat)
                    check_eq("fill_mem_address", 32'(mem_address), 32'(miss_pc[9:4]));
                if (e < n)
                    check_eq("fill_busywait", 32'(busywait), 32'd1);
            end
            m_blk[miss_pc[6:4]] = int'(miss_pc[9:4]);
        end
    endtask

    task automatic random_pc(output logic [31:0] a);
        logic [31:0] r;
        logic [2:0]  t;
        logic [2:0]  idx;
        logic [1:0]  off;
        r   = $urandom();
        t   = 3'($urandom_range(0, 2));
        idx = 3'($urandom_range(0, 3));
        off = 2'($urandom_range(0, 3));
        a   = {r[31:10], t, idx, off, r[1:0]};
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        errors = 0;
        checks = 0;
        lat    = 3;
        reset  = 1'b1;
        pc     = 32'h0;
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 4; k++)
                mem_words[i][k] = $urandom();
        for (int k = 0; k < 4; k++) mem_words[0][k] = 32'(k);
        model_clear();

        // Reset held: stall and request both masked.
        @(negedge clk);
        #1;
        check_eq("rst_busywait", 32'(busywait), 32'd0);
        check_eq("rst_mem_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("post_rst_mem_read", 32'(mem_read), 32'd0);
        check_eq("post_rst_mem_address", 32'(mem_address), 32'd0);
        check_eq("post_rst_busywait", 32'(busywait), 32'd1);

        // Cold miss on block 0 with 3-cycle latency, then in-block hits.
        access(32'h000, 1'b0, 32'h0, 3);
        check_eq("cold_instruction", instruction, 32'h0000_0000);
        @(negedge clk); access(32'h004, 1'b0, 32'h0, 0);
        check_eq("blk_word1", instruction, 32'd1);
        @(negedge clk); access(32'h008, 1'b0, 32'h0, 0);
        check_eq("blk_word2", instruction, 32'd2);
        @(negedge clk); access(32'h00C, 1'b0, 32'h0, 0);
        check_eq("blk_word3", instruction, 32'd3);

        // Upper address bits alias onto the same block.
        @(negedge clk); access(32'h400, 1'b0, 32'h0, 0);
        check_eq("alias_instruction", instruction, 32'h0000_0000);

        // Conflict miss on index 0, then block 0 misses again.
        @(negedge clk); access(32'h080, 1'b0, 32'h0, 0);
        @(negedge clk);
        pc = 32'h000;
        #1;
        check_eq("conflict_remiss", 32'(busywait), 32'd1);
        access(32'h000, 1'b0, 32'h0, 0);

        // PC moves away during MEM_READ.
        @(negedge clk); access(32'h010, 1'b1, 32'h020, 0);
        @(negedge clk); access(32'h010, 1'b0, 32'h0, 0);

        // Reset during MEM_READ aborts the fetch.
        @(negedge clk);
        pc  = 32'h100;
        lat = 4;
        #2;
        check_eq("abort_miss", 32'(busywait), 32'd1);
        @(negedge clk);
        #2;
        check_eq("abort_in_mem_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check_eq("abort_rst_busywait", 32'(busywait), 32'd0);
        check_eq("abort_rst_mem_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pc    = 32'h000;
        model_clear();
        #1;
        check_eq("abort_mem_read", 32'(mem_read), 32'd0);
        check_eq("abort_mem_address", 32'(mem_address), 32'd0);
        check_eq("abort_busywait", 32'(busywait), 32'd1);
        access(32'h000, 1'b0, 32'h0, 0);

        // Random fetches, some with a PC switch during the miss.
        for (int i = 0; i < 200; i++) begin
            random_pc(a);
            random_pc(b);
            @(negedge clk);
            access(a, ($urandom_range(0, 3) == 0), b, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
